// File: rtl/e_divop.sv
// Iterative radix-2 restoring divider for the execute stage.
// Quotient is returned on Lo and remainder on Hi, mirroring the multiplier's HI/LO convention.
module e_divop #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             n_rst,
    input  logic             start,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q;     // dividend shifts out of the top, quotient bits shift in below
    logic [WIDTH-1:0] divs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] a_raw_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             neg_q_q;
    logic             neg_r_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic             take;

    // Handshake: start is sampled only while busy=0 (IDLE); busy stays high until the
    // FIX edge, after which done pulses for one cycle with busy already low, so a start
    // presented in the done cycle is accepted.
    assign busy = (state_q != IDLE);

    always_comb begin
        mag_a  = (i_signed && i_A[WIDTH-1]) ? (~i_A + 1'b1) : i_A;
        mag_b  = (i_signed && i_B[WIDTH-1]) ? (~i_B + 1'b1) : i_B;
        rem_sh = {rem_q, dvd_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, divs_q};
        take   = ~diff[WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (i_B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            dvd_q    <= '0;
            divs_q   <= '0;
            rem_q    <= '0;
            a_raw_q  <= '0;
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        dvd_q   <= mag_a;
                        divs_q  <= mag_b;
                        rem_q   <= '0;
                        a_raw_q <= i_A;
                        cnt_q   <= '0;
                        zero_q  <= (i_B == '0);
                        neg_q_q <= i_signed & (i_A[WIDTH-1] ^ i_B[WIDTH-1]);
                        neg_r_q <= i_signed & i_A[WIDTH-1];
                    end
                end
                CALC: begin
                    rem_q <= take ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    dvd_q <= {dvd_q[WIDTH-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    done     <= 1'b1;
                    div_zero <= zero_q;
                    if (zero_q) begin
                        Lo <= '1;
                        Hi <= a_raw_q;
                    end else begin
                        Lo <= neg_q_q ? (~dvd_q + 1'b1) : dvd_q;
                        Hi <= neg_r_q ? (~rem_q + 1'b1) : rem_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_divop.sv
// Directed bench for e_divop: hand-computed quotient/remainder, latency, handshake and reset.
module tb_e_divop;

    logic        clock;
    logic        n_rst;
    logic        start;
    logic        i_signed;
    logic [31:0] i_A;
    logic [31:0] i_B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];

    e_divop #(.WIDTH(32)) dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .start    (start),
        .i_signed (i_signed),
        .i_A      (i_A),
        .i_B      (i_B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // drivers: called at a negedge, present the request for one edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start    = 1'b1;
        i_A      = a;
        i_B      = b;
        i_signed = s;
        @(negedge clock);
        start = 1'b0;
        i_A   = '0;
        i_B   = '0;
    endtask

    // counts edges after the start edge until done, with a bound
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 200) begin
            if (busy) busy_n++;
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input logic exp_dz, input int exp_lat);
        int lat, busy_n;
        exp_q.push_back(exp_lo);
        exp_q.push_back(exp_hi);
        launch(a, b, s);
        wait_done(lat, busy_n);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " Lo"}, Lo, exp_q.pop_front());
        check({tag, " Hi"}, Hi, exp_q.pop_front());
        check({tag, " div_zero"}, 32'(div_zero), 32'(exp_dz));
    endtask

    initial begin
        int lat, busy_n, pulses;
        n_rst    = 1'b0;
        start    = 1'b0;
        i_signed = 1'b0;
        i_A      = '0;
        i_B      = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset Lo", Lo, 32'd0);
        check("reset Hi", Hi, 32'd0);
        check("reset div_zero", 32'(div_zero), 32'd0);
        n_rst = 1'b1;
        @(negedge clock);

        // unsigned 100/7 with busy/latency observation
        launch(32'd100, 32'd7, 1'b0);
        wait_done(lat, busy_n);
        check("u100/7 latency", 32'(lat), 32'd33);
        check("u100/7 busy cycles", 32'(busy_n), 32'd33);
        check("u100/7 busy in done", 32'(busy), 32'd0);
        check("u100/7 Lo", Lo, 32'd14);
        check("u100/7 Hi", Hi, 32'd2);
        check("u100/7 div_zero", 32'(div_zero), 32'd0);
        @(negedge clock);
        check("done one cycle", 32'(done), 32'd0);
        check("Lo held", Lo, 32'd14);

        run_div("s-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
        run_div("s7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
        run_div("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div("u ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 33);
        run_div("s 5/0", 32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run_div("u 5/0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        repeat (4) @(negedge clock);
        check("div_zero held", 32'(div_zero), 32'd1);
        run_div("u9/3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

        // start pulsed with 50/5 during CALC must be ignored
        launch(32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clock);
        launch(32'd50, 32'd5, 1'b0);
        wait_done(lat, busy_n);
        check("ignore latency", 32'(lat + 6), 32'd33);
        check("ignore Lo", Lo, 32'd14);
        check("ignore Hi", Hi, 32'd2);

        // back-to-back: start held in the done cycle
        launch(32'd50, 32'd5, 1'b0);
        wait_done(lat, busy_n);
        check("b2b first Lo", Lo, 32'd10);
        check("b2b first Hi", Hi, 32'd0);
        launch(32'd77, 32'd10, 1'b0);
        wait_done(lat, busy_n);
        check("b2b second latency", 32'(lat), 32'd33);
        check("b2b second Lo", Lo, 32'd7);
        check("b2b second Hi", Hi, 32'd7);

        // asynchronous reset mid-operation
        launch(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clock);
        #2 n_rst = 1'b0;
        #1;
        check("mid reset Lo", Lo, 32'd0);
        check("mid reset Hi", Hi, 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        n_rst  = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) pulses++;
        end
        check("aborted op no done", 32'(pulses), 32'd0);
        run_div("u1000/10", 32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
